// File: rtl/axi_read_arbiter.sv
// Round-robin arbiter sharing one AXI read port among NUM_REQ requesters.
// Define FIXED_PRIORITY_EN for lowest-index-wins arbitration.
module axi_read_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  flush,
    input  logic [NUM_REQ-1:0]    req_arvalid,
    output logic [NUM_REQ-1:0]    req_arready,
    input  logic [NUM_REQ*32-1:0] req_araddr,
    input  logic [NUM_REQ*4-1:0]  req_arlen,
    input  logic [NUM_REQ*3-1:0]  req_arsize,
    output logic [NUM_REQ-1:0]    req_rvalid,
    input  logic [NUM_REQ-1:0]    req_rready,
    output logic [31:0]           req_rdata,
    output logic [1:0]            req_rresp,
    output logic                  req_rlast,
    output logic [ID_W-1:0]       arid,
    output logic [31:0]           araddr,
    output logic [3:0]            arlen,
    output logic [2:0]            arsize,
    output logic [1:0]            arburst,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [ID_W-1:0]       rid,
    input  logic [31:0]           rdata,
    input  logic [1:0]            rresp,
    input  logic                  rlast,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [NUM_REQ-1:0]    grant,
    output logic                  busy,
    output logic                  err
);

    localparam int PW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DRAIN
    } state_t;

    state_t            state;
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     winner;
    logic [NUM_REQ-1:0] win_oh;
    logic              found;
    logic [3:0]        beat_cnt;
    logic              flush_pend;
    logic              beat;
    logic              beat_bad;

    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FIXED_PRIORITY_EN
            idx = k;
`else
            idx = (int'(rr_ptr) + k) % NUM_REQ;
`endif
            if (!found && req_arvalid[idx]) begin
                found  = 1'b1;
                winner = PW'(idx);
            end
        end
        win_oh = NUM_REQ'(1) << winner;
    end

    assign req_arready = (state == S_IDLE && found && !flush) ? win_oh : '0;

    always_comb begin
        rready     = 1'b0;
        req_rvalid = '0;
        unique case (state)
            S_R: begin
                rready     = req_rready[owner];
                req_rvalid = NUM_REQ'(rvalid) << owner;
            end
            S_DRAIN: rready = 1'b1;
            default: ;
        endcase
    end

    assign beat      = rvalid & rready;
    // Protocol error: wrong ID, or rlast disagreeing with the beat count.
    assign beat_bad  = (rid != arid) || (rlast != (beat_cnt == arlen));
    assign req_rdata = rdata;
    assign req_rresp = rresp;
    assign req_rlast = rlast;
    assign arburst   = 2'b01;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            arvalid    <= 1'b0;
            grant      <= '0;
            err        <= 1'b0;
            rr_ptr     <= '0;
            owner      <= '0;
            beat_cnt   <= '0;
            flush_pend <= 1'b0;
            arid       <= '0;
            araddr     <= '0;
            arlen      <= '0;
            arsize     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (found && !flush) begin
                        araddr     <= req_araddr[int'(winner)*32 +: 32];
                        arlen      <= req_arlen[int'(winner)*4 +: 4];
                        arsize     <= req_arsize[int'(winner)*3 +: 3];
                        arid       <= ID_W'(winner);
                        owner      <= winner;
                        grant      <= win_oh;
                        arvalid    <= 1'b1;
                        flush_pend <= 1'b0;
                        state      <= S_AR;
`ifdef FIXED_PRIORITY_EN
                        rr_ptr     <= '0;
`else
                        rr_ptr     <= (int'(winner) == NUM_REQ - 1)
                                      ? '0 : winner + 1'b1;
`endif
                    end
                end
                S_AR: begin
                    // A flush seen while waiting must still drain the burst.
                    if (flush) flush_pend <= 1'b1;
                    if (arready) begin
                        arvalid  <= 1'b0;
                        beat_cnt <= '0;
                        state    <= (flush || flush_pend) ? S_DRAIN : S_R;
                    end
                end
                S_R: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_bad) err <= 1'b1;
                    end
                    if (beat && rlast) begin
                        grant <= '0;
                        state <= S_IDLE;
                    end else if (flush) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (rvalid && rlast) begin
                        grant <= '0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
